alu_mp_sequencer: RTL and testbench

ALU_MP_SEQUENCER -- requirements
Module: alu_mp_sequencer

---
 rtl/alu_mp_pkg.sv | 28 ++
 rtl/alu_mp_sequencer.sv | 165 ++++++++++++++++
 tb/tb_alu_mp_sequencer.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/alu_mp_pkg.sv
// Shared encodings for the multi-word ALU sequencer: ALU op codes and
// sequencer states, plus a legality helper for incoming op codes.
package alu_mp_pkg;

  localparam logic [2:0] OP_PASS = 3'd0;
  localparam logic [2:0] OP_NOT  = 3'd1;
  localparam logic [2:0] OP_ADD  = 3'd2;
  localparam logic [2:0] OP_SUB  = 3'd3;
  localparam logic [2:0] OP_OR   = 3'd4;
  localparam logic [2:0] OP_AND  = 3'd5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  // Ops 6 and 7 are undefined and answered with an error response.
  function automatic logic op_legal(input logic [2:0] op);
    return op <= OP_AND;
  endfunction

  // Add and subtract chain a carry across words; everything else is bitwise.
  function automatic logic op_arith(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/alu_mp_sequencer.sv
// Multi-word ALU sequencer: accepts an NW-word command, streams one word per
// cycle through an external combinational ALU (alu_* ports) chaining the
// carry, and returns the assembled NW-word result with a ready/valid response.
// Subtract is issued as A + ~B + 1, so rsp_c_out = 1 means "no borrow".
// Optional feature macro: ALU_MP_ZERO_FLAG_EN adds the rsp_zero output.
module alu_mp_sequencer
  import alu_mp_pkg::*;
#(
  parameter int W  = 32,
  parameter int NW = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [2:0]      cmd_op,
  input  logic            cmd_c_in,
  input  logic [NW*W-1:0] cmd_a,
  input  logic [NW*W-1:0] cmd_b,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [NW*W-1:0] rsp_result,
  output logic            rsp_c_out,
  output logic            rsp_err,
  output logic [W-1:0]    alu_a,
  output logic [W-1:0]    alu_b,
  output logic [2:0]      alu_op,
  output logic            alu_c_in,
  input  logic [W-1:0]    alu_result,
  input  logic            alu_c_out
`ifdef ALU_MP_ZERO_FLAG_EN
  ,
  output logic            rsp_zero
`endif
);

  localparam int KW = (NW > 1) ? $clog2(NW) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NW - 1);

  state_e            state_q, state_d;
  logic [KW-1:0]     k_q, k_d;
  logic [2:0]        op_q, op_d;
  logic              carry_q, carry_d;
  logic [NW*W-1:0]   a_q, a_d, b_q, b_d;
  logic [NW*W-1:0]   result_q, result_d;
  logic              c_out_q, c_out_d;
  logic              err_q, err_d;
`ifdef ALU_MP_ZERO_FLAG_EN
  logic              zero_q, zero_d;
`endif

  // Next-state, datapath updates and ALU drive; ALU inputs are zero outside EXEC.
  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    op_d     = op_q;
    carry_d  = carry_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    c_out_d  = c_out_q;
    err_d    = err_q;
`ifdef ALU_MP_ZERO_FLAG_EN
    zero_d   = zero_q;
`endif
    alu_a    = '0;
    alu_b    = '0;
    alu_op   = OP_PASS;
    alu_c_in = 1'b0;

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          a_d      = cmd_a;
          b_d      = cmd_b;
          op_d     = cmd_op;
          k_d      = '0;
          result_d = '0;
          c_out_d  = 1'b0;
`ifdef ALU_MP_ZERO_FLAG_EN
          zero_d   = 1'b0;
`endif
          // Carry into word 0: +1 completes the two's complement for subtract.
          carry_d  = (cmd_op == OP_SUB) ? 1'b1 :
                     (cmd_op == OP_ADD) ? cmd_c_in : 1'b0;
          if (op_legal(cmd_op)) begin
            err_d   = 1'b0;
            state_d = EXEC;
          end else begin
            err_d   = 1'b1;
            state_d = RESP;
          end
        end
      end

      EXEC: begin
        alu_a    = a_q[k_q*W +: W];
        alu_b    = (op_q == OP_SUB) ? ~b_q[k_q*W +: W] : b_q[k_q*W +: W];
        alu_op   = (op_q == OP_SUB) ? OP_ADD : op_q;
        alu_c_in = op_arith(op_q) ? carry_q : 1'b0;
        result_d[k_q*W +: W] = alu_result;
        carry_d  = alu_c_out;
        if (k_q == K_LAST) begin
          c_out_d = op_arith(op_q) ? alu_c_out : 1'b0;
`ifdef ALU_MP_ZERO_FLAG_EN
          zero_d  = (result_d == '0);
`endif
          state_d = RESP;
        end else begin
          k_d = k_q + KW'(1);
        end
      end

      RESP: begin
        if (rsp_ready) begin
          k_d     = '0;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any in-flight command.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      k_q      <= '0;
      op_q     <= OP_PASS;
      carry_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      c_out_q  <= 1'b0;
      err_q    <= 1'b0;
`ifdef ALU_MP_ZERO_FLAG_EN
      zero_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      op_q     <= op_d;
      carry_q  <= carry_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      c_out_q  <= c_out_d;
      err_q    <= err_d;
`ifdef ALU_MP_ZERO_FLAG_EN
      zero_q   <= zero_d;
`endif
    end
  end

  assign cmd_ready  = (state_q == IDLE);
  assign rsp_valid  = (state_q == RESP);
  assign rsp_result = result_q;
  assign rsp_c_out  = c_out_q;
  assign rsp_err    = err_q;
`ifdef ALU_MP_ZERO_FLAG_EN
  assign rsp_zero   = zero_q;
`endif

endmodule

// File: tb/tb_alu_mp_sequencer.sv
// Bench for alu_mp_sequencer (W=32, NW=4): models the external ALU, checks
// each response against a whole-operand arithmetic reference.
// Honors ALU_MP_ZERO_FLAG_EN when defined.
module tb_alu_mp_sequencer;

  localparam int W  = 32;
  localparam int NW = 4;
  localparam int DW = NW * W;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid, cmd_ready, cmd_c_in;
  logic [2:0]    cmd_op;
  logic [DW-1:0] cmd_a, cmd_b;
  logic          rsp_valid, rsp_ready, rsp_c_out, rsp_err;
  logic [DW-1:0] rsp_result;
  logic [W-1:0]  alu_a, alu_b, alu_result;
  logic [2:0]    alu_op;
  logic          alu_c_in, alu_c_out;
`ifdef ALU_MP_ZERO_FLAG_EN
  logic          rsp_zero;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  alu_mp_sequencer #(.W(W), .NW(NW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_c_in(cmd_c_in), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_c_out(rsp_c_out), .rsp_err(rsp_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_c_in(alu_c_in),
    .alu_result(alu_result), .alu_c_out(alu_c_out)
`ifdef ALU_MP_ZERO_FLAG_EN
    , .rsp_zero(rsp_zero)
`endif
  );

  // External combinational ALU, same op encoding as the command.
  always_comb begin
    logic [W:0] s;
    s = '0;
    case (alu_op)
      3'd0: s = {1'b0, alu_a};
      3'd1: s = {1'b0, ~alu_a};
      3'd2: s = {1'b0, alu_a} + {1'b0, alu_b} + {{W{1'b0}}, alu_c_in};
      3'd3: s = {1'b0, alu_a - alu_b};
      3'd4: s = {1'b0, alu_a | alu_b};
      3'd5: s = {1'b0, alu_a & alu_b};
      default: s = '0;
    endcase
    alu_result = s[W-1:0];
    alu_c_out  = s[W];
  end

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Whole-operand reference: plain wide arithmetic, no word sequencing.
  task automatic ref_model(input logic [2:0] op, input logic cin,
                           input logic [DW-1:0] a, input logic [DW-1:0] b,
                           output logic [DW-1:0] r, output logic c, output logic e);
    logic [DW:0] s;
    e = 1'b0; c = 1'b0; r = '0;
    case (op)
      3'd0: r = a;
      3'd1: r = ~a;
      3'd2: begin s = {1'b0, a} + {1'b0, b} + DW'(cin); r = s[DW-1:0]; c = s[DW]; end
      3'd3: begin r = a - b; c = (a >= b); end
      3'd4: r = a | b;
      3'd5: r = a & b;
      default: e = 1'b1;
    endcase
  endtask

  function automatic logic [DW-1:0] rnd_word();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Issue one command, measure latency, apply bp cycles of backpressure,
  // then complete the handshake. Latency = edges from accept until rsp_valid
  // is seen: NW for legal ops; illegal ops show rsp_valid in the very first
  // cycle after accept with no EXEC cycles in between.
  task automatic run_cmd(input logic [2:0] op, input logic cin,
                         input logic [DW-1:0] a, input logic [DW-1:0] b, input int bp);
    logic [DW-1:0] er; logic ec, ee;
    int lat;
    logic op_seen;
    ref_model(op, cin, a, b, er, ec, ee);
    @(negedge clk);
    chk("cmd_ready_idle", DW'(cmd_ready), DW'(1));
    cmd_valid = 1'b1; cmd_op = op; cmd_c_in = cin; cmd_a = a; cmd_b = b;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0; cmd_a = rnd_word(); cmd_b = rnd_word(); cmd_op = 3'($urandom);
    lat = 0;
    op_seen = (alu_op != 3'd0);
    while (!rsp_valid && lat < 50) begin
      @(posedge clk); @(negedge clk);
      lat++;
      if (!rsp_valid) op_seen = op_seen | (alu_op != 3'd0);
    end
    chk("latency", DW'(lat), ee ? DW'(0) : DW'(NW));
    if (ee) chk("illegal_alu_op_idle", DW'(op_seen), DW'(0));
    chk("result", rsp_result, er);
    chk("c_out", DW'(rsp_c_out), DW'(ec));
    chk("err", DW'(rsp_err), DW'(ee));
`ifdef ALU_MP_ZERO_FLAG_EN
    chk("zero", DW'(rsp_zero), DW'(!ee && er == '0));
`endif
    for (int i = 0; i < bp; i++) begin
      @(posedge clk); @(negedge clk);
      chk("bp_valid", DW'(rsp_valid), DW'(1));
      chk("bp_result", rsp_result, er);
      chk("bp_cready", DW'({cmd_ready, rsp_c_out, rsp_err}), DW'({1'b0, ec, ee}));
    end
    rsp_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    rsp_ready = 1'b0;
    chk("back_idle", DW'({rsp_valid, cmd_ready}), DW'(2'b01));
  endtask

  initial begin
    logic [DW-1:0] ones, a0;
    int seen;
    ones = '1;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_c_in = 1'b0;
    cmd_a = '0; cmd_b = '0; rsp_ready = 1'b0;
    #12;
    chk("rst_cready", DW'(cmd_ready), DW'(1));
    chk("rst_rvalid", DW'(rsp_valid), DW'(0));
    chk("rst_result", rsp_result, '0);
    chk("rst_flags", DW'({rsp_c_out, rsp_err}), DW'(0));
    chk("rst_alu", {alu_a, alu_b, 28'd0, alu_op, alu_c_in}, '0);
    @(negedge clk); rst_n = 1'b1;

    // Directed corner cases.
    run_cmd(3'd2, 1'b0, 128'h0000_0000_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 128'd1, 0);
    run_cmd(3'd3, 1'b1, 128'd0, 128'd1, 0);
    run_cmd(3'd3, 1'b0, 128'd5, 128'd3, 0);
    run_cmd(3'd2, 1'b1, ones, ones, 0);
    run_cmd(3'd6, 1'b0, rnd_word(), rnd_word(), 0);
    run_cmd(3'd5, 1'b0, rnd_word(), rnd_word(), 5);

    // Reset while word 2 is in the ALU.
    a0 = rnd_word();
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 3'd2; cmd_c_in = 1'b0; cmd_a = a0; cmd_b = rnd_word();
    @(posedge clk); @(negedge clk);
    cmd_valid = 1'b0;
    @(posedge clk); @(posedge clk); #2;
    chk("word2_alu_a", DW'(alu_a), DW'(a0[95:64]));
    rst_n = 1'b0; #1;
    chk("async_rst_state", DW'({rsp_valid, cmd_ready}), DW'(2'b01));
    chk("async_rst_alu", {alu_a, alu_b, 28'd0, alu_op, alu_c_in}, '0);
    @(negedge clk); rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); @(negedge clk);
      if (rsp_valid) seen++;
    end
    chk("no_rsp_after_rst", DW'(seen), DW'(0));
    run_cmd(3'd5, 1'b0, 128'hF0, 128'h3C, 0);

    // Randomized commands, including illegal ops and backpressure.
    for (int i = 0; i < 30; i++)
      run_cmd(3'($urandom_range(0, 7)), 1'($urandom), rnd_word(), rnd_word(),
              int'($urandom_range(0, 3)));
    run_cmd(3'd3, 1'b0, 128'd7, 128'd7, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
